// File: rtl/gpu_pkg.sv
// Shared types and helpers for the instruction-pipe program counter.
package gpu_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_SLOT = 2'd2
    } pc_state_e;

    localparam logic [31:0] INS_BYTES   = 32'd2;
    localparam logic [31:0] MOVEI_BYTES = 32'd6;

    // JR offsets count 16-bit words; widen to a signed byte offset.
    function automatic logic [31:0] sext5_word(input logic [4:0] offset);
        return {{26{offset[4]}}, offset, 1'b0};
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational candidate next-PC values: sequential, branch-slot, JR target, vector.
module pc_target_calc
    import gpu_pkg::*;
#(
    parameter logic [31:0] INT_BASE        = 32'h00F03000,
    parameter int          INT_STRIDE_LOG2 = 4
) (
    input  logic [31:0] pc_i,
    input  logic        ins_imm_i,
    input  logic [4:0]  jr_offset_i,
    input  logic [2:0]  int_num_i,
    output logic [31:0] seq_pc_o,
    output logic [31:0] slot_pc_o,
    output logic [31:0] jr_target_o,
    output logic [31:0] vec_pc_o
);

    logic [31:0] vec_raw;

    always_comb begin
        seq_pc_o    = pc_i + (ins_imm_i ? MOVEI_BYTES : INS_BYTES);
        slot_pc_o   = pc_i + INS_BYTES;
        jr_target_o = (slot_pc_o + sext5_word(jr_offset_i)) & ~32'd1;
        vec_raw     = INT_BASE + ({29'd0, int_num_i} << INT_STRIDE_LOG2);
        vec_pc_o    = vec_raw & ~32'd1;
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential advance, one-slot delayed JR/JUMP,
// interrupt vectoring, and host PC loads while stopped.
module pc_gen
    import gpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h00F03000,
    parameter logic [31:0] INT_BASE        = 32'h00F03000,
    parameter int          INT_STRIDE_LOG2 = 4
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        go,
    input  logic        pc_wr,
    input  logic [31:0] pc_wdata,
    input  logic        ins_advance,
    input  logic        ins_imm,
    input  logic        jr_take,
    input  logic [4:0]  jr_offset,
    input  logic        jump_take,
    input  logic [31:0] jump_addr,
    input  logic        int_req,
    input  logic [2:0]  int_num,
    output logic [31:0] program_count,
    output logic        running,
    output logic [31:0] ret_pc,
    output logic        int_ack,
    output logic        slot_err
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] ret_pc_q, ret_pc_d;
    logic        int_ack_q, int_ack_d;
    logic        slot_err_q, slot_err_d;
    logic        running_q, running_d;

    logic [31:0] seq_pc, slot_pc, jr_target, vec_pc;

    pc_target_calc #(
        .INT_BASE        (INT_BASE),
        .INT_STRIDE_LOG2 (INT_STRIDE_LOG2)
    ) u_calc (
        .pc_i        (pc_q),
        .ins_imm_i   (ins_imm),
        .jr_offset_i (jr_offset),
        .int_num_i   (int_num),
        .seq_pc_o    (seq_pc),
        .slot_pc_o   (slot_pc),
        .jr_target_o (jr_target),
        .vec_pc_o    (vec_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        ret_pc_d   = ret_pc_q;
        int_ack_d  = 1'b0;
        slot_err_d = 1'b0;

        case (state_q)
            ST_STOP: begin
                if (pc_wr) begin
                    pc_d = {pc_wdata[31:1], 1'b0};
                end
                if (go) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!go) begin
                    state_d  = ST_STOP;
                    target_d = '0;
                end else if (ins_advance) begin
                    if (jump_take) begin
                        target_d = {jump_addr[31:1], 1'b0};
                        pc_d     = slot_pc;
                        state_d  = ST_SLOT;
                    end else if (jr_take) begin
                        target_d = jr_target;
                        pc_d     = slot_pc;
                        state_d  = ST_SLOT;
                    end else if (int_req) begin
                        ret_pc_d  = seq_pc;
                        pc_d      = vec_pc;
                        int_ack_d = 1'b1;
                    end else begin
                        pc_d = seq_pc;
                    end
                end
            end
            ST_SLOT: begin
                if (!go) begin
                    state_d  = ST_STOP;
                    target_d = '0;
                end else if (ins_advance) begin
                    // Branches in the slot are dropped; interrupts wait for RUN.
                    pc_d       = target_q;
                    state_d    = ST_RUN;
                    slot_err_d = jr_take | jump_take;
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase

        running_d = (state_d != ST_STOP);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q    <= ST_STOP;
            pc_q       <= RESET_PC;
            target_q   <= '0;
            ret_pc_q   <= '0;
            int_ack_q  <= 1'b0;
            slot_err_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            ret_pc_q   <= ret_pc_d;
            int_ack_q  <= int_ack_d;
            slot_err_q <= slot_err_d;
            running_q  <= running_d;
        end
    end

    assign program_count = pc_q;
    assign running       = running_q;
    assign ret_pc        = ret_pc_q;
    assign int_ack       = int_ack_q;
    assign slot_err      = slot_err_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with a cycle-level reference model and literal checkpoints.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset, go, pc_wr, ins_advance, ins_imm, jr_take, jump_take, int_req;
    logic [31:0] pc_wdata, jump_addr;
    logic [4:0]  jr_offset;
    logic [2:0]  int_num;
    logic [31:0] program_count, ret_pc;
    logic        running, int_ack, slot_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: mode flags and registers as the behaviour describes them.
    bit          m_run, m_slot, m_ack, m_serr;
    logic [31:0] m_pc, m_target, m_ret;

    always #5 clk = ~clk;

    pc_gen dut (
        .sys_clk       (clk),
        .reset         (reset),
        .go            (go),
        .pc_wr         (pc_wr),
        .pc_wdata      (pc_wdata),
        .ins_advance   (ins_advance),
        .ins_imm       (ins_imm),
        .jr_take       (jr_take),
        .jr_offset     (jr_offset),
        .jump_take     (jump_take),
        .jump_addr     (jump_addr),
        .int_req       (int_req),
        .int_num       (int_num),
        .program_count (program_count),
        .running       (running),
        .ret_pc        (ret_pc),
        .int_ack       (int_ack),
        .slot_err      (slot_err)
    );

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0; m_slot = 0; m_ack = 0; m_serr = 0;
            m_pc = 32'h00F03000; m_target = 0; m_ret = 0;
        end else begin
            m_ack = 0; m_serr = 0;
            if (!m_run) begin
                if (pc_wr) m_pc = pc_wdata & 32'hFFFF_FFFE;
                if (go) m_run = 1;
            end else if (!go) begin
                m_run = 0; m_slot = 0;
            end else if (ins_advance) begin
                if (m_slot) begin
                    m_serr = jr_take || jump_take;
                    m_pc = m_target;
                    m_slot = 0;
                end else if (jump_take) begin
                    m_target = jump_addr & 32'hFFFF_FFFE;
                    m_pc = m_pc + 2;
                    m_slot = 1;
                end else if (jr_take) begin
                    m_target = (m_pc + 2 + 32'($signed(jr_offset)) * 2) & 32'hFFFF_FFFE;
                    m_pc = m_pc + 2;
                    m_slot = 1;
                end else if (int_req) begin
                    m_ret = m_pc + (ins_imm ? 6 : 2);
                    m_pc = 32'h00F03000 + 32'(int_num) * 16;
                    m_ack = 1;
                end else begin
                    m_pc = m_pc + (ins_imm ? 6 : 2);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.pc", program_count, m_pc);
            chk("model.running", {31'd0, running}, {31'd0, m_run});
            chk("model.ret_pc", ret_pc, m_ret);
            chk("model.int_ack", {31'd0, int_ack}, {31'd0, m_ack});
            chk("model.slot_err", {31'd0, slot_err}, {31'd0, m_serr});
        end
    end

    task automatic idle();
        pc_wr = 0; ins_advance = 0; ins_imm = 0; jr_take = 0; jump_take = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input logic imm);
        idle(); ins_advance = 1; ins_imm = imm;
        tick();
        idle();
    endtask

    task automatic load_pc(input logic [31:0] v);
        idle(); go = 0; tick();
        pc_wr = 1; pc_wdata = v; go = 1; tick();
        idle();
    endtask

    initial begin
        reset = 1; go = 0; pc_wdata = 0; jump_addr = 0; jr_offset = 0;
        int_req = 0; int_num = 0;
        idle();
        tick(); tick();
        chk_en = 1;
        chk("rst.pc", program_count, 32'h00F03000);
        chk("rst.running", {31'd0, running}, 32'd0);
        chk("rst.ret_pc", ret_pc, 32'd0);
        reset = 0;

        go = 1; tick();
        chk("go.running", {31'd0, running}, 32'd1);
        chk("go.pc", program_count, 32'h00F03000);
        adv(0); chk("seq.1", program_count, 32'h00F03002);
        adv(1); chk("seq.movei", program_count, 32'h00F03008);
        adv(0); chk("seq.3", program_count, 32'h00F0300A);
        adv(1); chk("seq.4", program_count, 32'h00F03010);

        jr_offset = 5'b11100;
        jr_take = 1; ins_advance = 1; tick(); idle();
        chk("jr.slot", program_count, 32'h00F03012);
        adv(1);
        chk("jr.target", program_count, 32'h00F0300A);
        chk("jr.no_err", {31'd0, slot_err}, 32'd0);

        load_pc(32'h00F03020);
        chk("load.3020", program_count, 32'h00F03020);
        jump_addr = 32'h00F03101;
        jump_take = 1; ins_advance = 1; tick(); idle();
        chk("jump.slot", program_count, 32'h00F03022);
        jump_addr = 32'h00F03400;
        jump_take = 1; ins_advance = 1; tick(); idle();
        chk("jump.target", program_count, 32'h00F03100);
        chk("jump.slot_err", {31'd0, slot_err}, 32'd1);
        tick();
        chk("jump.err_pulse", {31'd0, slot_err}, 32'd0);

        load_pc(32'h00F03040);
        int_req = 1; int_num = 3;
        adv(1);
        int_req = 0;
        chk("int.ret", ret_pc, 32'h00F03046);
        chk("int.vec", program_count, 32'h00F03030);
        chk("int.ack", {31'd0, int_ack}, 32'd1);
        tick();
        chk("int.ack_pulse", {31'd0, int_ack}, 32'd0);

        jr_offset = 5'd0;
        jr_take = 1; ins_advance = 1; tick(); idle();
        int_req = 1;
        adv(0);
        chk("int.defer_pc", program_count, 32'h00F03032);
        chk("int.defer_ack", {31'd0, int_ack}, 32'd0);
        adv(0);
        int_req = 0;
        chk("int.late_ack", {31'd0, int_ack}, 32'd1);
        chk("int.late_ret", ret_pc, 32'h00F03034);
        chk("int.late_vec", program_count, 32'h00F03030);

        load_pc(32'hFFFF_FFFE);
        adv(0);
        chk("wrap", program_count, 32'h0000_0000);
        go = 0; ins_advance = 1; tick(); idle();
        chk("stop.hold", program_count, 32'h0000_0000);
        chk("stop.running", {31'd0, running}, 32'd0);
        pc_wr = 1; pc_wdata = 32'h00F03201; tick(); idle();
        chk("stop.load", program_count, 32'h00F03200);
        go = 1; tick();
        pc_wr = 1; pc_wdata = 32'h12345678; tick(); idle();
        chk("run.wr_ignored", program_count, 32'h00F03200);

        jump_addr = 32'h00F03500;
        jump_take = 1; ins_advance = 1; tick(); idle();
        chk("rstslot.slot", program_count, 32'h00F03202);
        reset = 1; tick(); reset = 0;
        chk("rstslot.pc", program_count, 32'h00F03000);
        chk("rstslot.running", {31'd0, running}, 32'd0);
        go = 1; tick();
        adv(0);
        chk("rstslot.no_branch", program_count, 32'h00F03002);
        tick();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter generator for the GPU/DSP instruction pipe.
- Produces the `program_count` value that the source-data generator reads for PC-relative and PC-move operands.
- Advances the PC per consumed instruction, honours one-instruction delayed branches (JR and JUMP), accepts interrupt vectoring, and allows host PC loads while stopped.

Parameters:
- RESET_PC, 32'h00F03000, PC value after reset.
- INT_BASE, 32'h00F03000, base address of the interrupt vector table.
- INT_STRIDE_LOG2, 4, log2 of the byte spacing between vectors (16 bytes).

Ports:
- sys_clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- go  in  1  run enable; low = stopped.
- pc_wr  in  1  host PC load strobe; honoured only in STOP.
- pc_wdata  in  32  host PC value.
- ins_advance  in  1  current instruction consumed this cycle.
- ins_imm  in  1  current instruction is MOVEI; it occupies 6 bytes.
- jr_take  in  1  taken relative branch; qualified by ins_advance.
- jr_offset  in  5  signed word offset for JR.
- jump_take  in  1  taken absolute jump; qualified by ins_advance.
- jump_addr  in  32  absolute jump target.
- int_req  in  1  interrupt request; level-held until int_ack.
- int_num  in  3  interrupt number.
- program_count  out  32  current instruction address.
- running  out  1  high in RUN or SLOT.
- ret_pc  out  32  return address captured on interrupt entry.
- int_ack  out  1  one-cycle pulse when an interrupt is taken.
- slot_err  out  1  one-cycle pulse when a branch is requested inside a delay slot.

Behaviour:
- Reset values:
  - state = STOP, program_count = RESET_PC, target = 0, ret_pc = 0.
  - int_ack = 0, slot_err = 0, running = 0.
- All arithmetic is 32-bit modulo 2^32 (wraps silently). Bit 0 of every loaded value (pc_wdata, jump_addr, computed targets) is forced to 0.
- Latency: program_count reflects an event one cycle after the event's input edge.
- STOP:
  - pc_wr: program_count <= pc_wdata & ~1.
  - go = 1: next state RUN. pc_wr in the same cycle still loads first, and RUN starts from the loaded value.
- RUN, on ins_advance (nothing changes without ins_advance):
  - jump_take = 1 (priority over jr_take): target <= jump_addr & ~1; program_count <= pc + 2; state SLOT.
  - else jr_take = 1: target <= pc + 2 + (sext(jr_offset) << 1); program_count <= pc + 2; state SLOT.
  - else int_req = 1: ret_pc <= pc + (ins_imm ? 6 : 2); program_count <= INT_BASE + (int_num << INT_STRIDE_LOG2); int_ack = 1; stay RUN.
  - else: program_count <= pc + (ins_imm ? 6 : 2).
  - ins_imm is ignored when a branch is taken.
- SLOT, on ins_advance:
  - program_count <= target; state RUN.
  - ins_imm in the slot does not alter the target.
  - jr_take or jump_take in the slot: the request is ignored and slot_err pulses.
  - int_req is deferred; it is not taken in SLOT and is not acked.
- go = 0 in RUN or SLOT: next state STOP. program_count holds its value, the pending target is discarded, and a coincident ins_advance is ignored.
- pc_wr outside STOP: ignored.
- reset mid-operation: all state returns to reset values next edge regardless of other inputs.
- running = (state != STOP); registered with the state.

Decomposition:
- Shared package (gpu_pkg):
  - state enum {STOP, RUN, SLOT}.
  - constants INS_BYTES = 2, MOVEI_BYTES = 6.
  - function sext5_word(offset) -> 32-bit byte offset.
- One natural sub-module, pc_target_calc: a combinational next-PC/target adder (sequential, MOVEI, JR, vector).
- FSM and registers stay in pc_gen.

Test Plan:
- Reset then go=1, three ins_advance with ins_imm=0,1,0 -> program_count 00F03000 -> 00F03002 -> 00F03008 -> 00F0300A; running=1.
- At PC 00F03010, jr_take with jr_offset=5'b11100 (-4) -> PC 00F03012 (slot), then on next advance 00F0300A; slot_err stays 0.
- jump_take with jump_addr=00F03101 at PC 00F03020, slot instruction also jump_take -> PC 00F03022, then 00F03100; slot_err pulses once.
- int_req, int_num=3, at PC 00F03040 with ins_imm=1 -> ret_pc=00F03046, PC=00F03030, int_ack one cycle. Same request arriving in SLOT -> taken only on the first RUN advance after the slot.
- PC FFFFFFFE, ins_advance -> 00000000 (wrap). Then go=0 with coincident ins_advance -> PC holds, STOP. pc_wr with 00F03201 -> 00F03200. pc_wr while running -> no change.
- reset asserted in SLOT with target pending -> next cycle PC=RESET_PC, STOP, no branch taken after re-go.
